// File: rtl/fifo2.sv
// ---------------------------------------------------------------------------
// fifo2 -- two-entry FIFO used as the per-channel buffer of demux2_buf.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst_aL  : asynchronous active-low reset; empties the FIFO and zeroes storage
//   push    : write wdata this cycle (ignored while full)
//   pop     : discard the head entry this cycle (ignored while empty)
//   wdata   : word to write
//   rdata   : head entry, read straight from storage at the read pointer
//   full    : occupancy is 2
//   empty   : occupancy is 0
// ---------------------------------------------------------------------------
module fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Occupancy comes from the count alone, so pointer wrap needs no care.
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is reset along with the control state so rdata reads 0
    // during and after reset; without that, stale words would be visible.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, independent of statement order.
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux2_buf.sv
// ---------------------------------------------------------------------------
// demux2_buf -- routes each accepted input word to one of two buffered
// output channels selected by in_sel, with a two-entry FIFO per channel.
//
// Ports
//   clk, rst_aL               : clock and asynchronous active-low reset
//   in_valid/in_ready/in_data : upstream handshake and payload
//   in_sel                    : destination channel of the current word
//   out0_valid/out0_ready/out0_data : channel 0 handshake and head word
//   out1_valid/out1_ready/out1_data : channel 1 handshake and head word
//
// in_ready depends only on in_sel and the registered FIFO state, never on
// the consumers' ready, so a full channel refuses a word even while it is
// being drained in the same cycle.
// ---------------------------------------------------------------------------
module demux2_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;
    logic accept;

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        in_ready = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        accept   = 1'b0;
        in_ready = in_sel ? !full1 : !full0;
        accept   = in_valid && in_ready;
        push0    = accept && !in_sel;
        push1    = accept && in_sel;
    end

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_ready && !empty0;
    assign pop1       = out1_ready && !empty1;

    fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .push   (push0),
        .pop    (pop0),
        .wdata  (in_data),
        .rdata  (out0_data),
        .full   (full0),
        .empty  (empty0)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .push   (push1),
        .pop    (pop1),
        .wdata  (in_data),
        .rdata  (out1_data),
        .full   (full1),
        .empty  (empty1)
    );

endmodule

// File: tb/tb_demux2_buf.sv
// ---------------------------------------------------------------------------
// tb_demux2_buf -- self-checking bench for demux2_buf. A queue per channel
// (capacity 2) is the reference: a word joins its queue on acceptance and
// leaves from the front when the consumer takes it.
// ---------------------------------------------------------------------------
module tb_demux2_buf;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_aL = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out0_valid;
    logic             out0_ready = 1'b0;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready = 1'b0;
    logic [WIDTH-1:0] out1_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] log0[$];
    logic [WIDTH-1:0] log1[$];

    always #5 clk = ~clk;

    demux2_buf #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_aL     (rst_aL),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    // One clock cycle: drive inputs, compare outputs against the queues,
    // then advance the queues across the edge. Returns the sampled in_ready.
    task automatic step(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1, output logic rdy_seen);
        logic exp_rdy;
        logic acc, p0, p1;
        in_valid   = v;
        in_sel     = sel;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        exp_rdy  = ((sel ? q1.size() : q0.size()) != 2);
        rdy_seen = in_ready;
        n_checks++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, exp_rdy);
        end
        n_checks++;
        if (out0_valid !== (q0.size() != 0)) begin
            n_fail++;
            $display("FAIL out0_valid t=%0t: got %b expected %b", $time, out0_valid, q0.size() != 0);
        end
        n_checks++;
        if (out1_valid !== (q1.size() != 0)) begin
            n_fail++;
            $display("FAIL out1_valid t=%0t: got %b expected %b", $time, out1_valid, q1.size() != 0);
        end
        if (q0.size() != 0) begin
            n_checks++;
            if (out0_data !== q0[0]) begin
                n_fail++;
                $display("FAIL out0_data t=%0t: got %h expected %h", $time, out0_data, q0[0]);
            end
        end
        if (q1.size() != 0) begin
            n_checks++;
            if (out1_data !== q1[0]) begin
                n_fail++;
                $display("FAIL out1_data t=%0t: got %h expected %h", $time, out1_data, q1[0]);
            end
        end
        acc = v && exp_rdy;
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) log0.push_back(q0.pop_front());
        if (p1) log1.push_back(q1.pop_front());
        if (acc) begin
            if (sel) q1.push_back(d);
            else     q0.push_back(d);
        end
        #1;
    endtask

    task automatic drain();
        logic r;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, r);
        log0.delete();
        log1.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid: got %b%b expected 00", tag, out0_valid, out1_valid);
        end
        n_checks++;
        if (out0_data !== '0 || out1_data !== '0) begin
            n_fail++;
            $display("FAIL %s data: got %h/%h expected 0/0", tag, out0_data, out1_data);
        end
        for (int s = 0; s < 2; s++) begin
            in_sel = s[0];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s in_ready sel=%0d: got %b expected 1", tag, s, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        #12;
        check_reset_outputs("reset");
        #2 rst_aL = 1'b1;   // released between edges
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_word();
        logic r;
        // First edge after reset release already accepts.
        step(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, r);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hA5A5_A5A5 || out1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_word: got v0=%b d0=%h v1=%b expected 1 a5a5a5a5 0",
                     out0_valid, out0_data, out1_valid);
        end
        drain();
    endtask

    task automatic test_fill_ch1();
        logic r;
        step(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, r);
        step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, r);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, r);
        n_checks++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ch1 ready sel1: got %b expected 0", r);
        end
        // Channel 1 full must not block channel 0.
        step(1'b1, 1'b0, 32'h33, 1'b0, 1'b0, r);
        n_checks++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ch1 ready sel0: got %b expected 1", r);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, r);
        drain();
    endtask

    task automatic test_full_pop();
        logic r;
        step(1'b1, 1'b0, 32'h1, 1'b0, 1'b0, r);
        step(1'b1, 1'b0, 32'h2, 1'b0, 1'b0, r);
        step(1'b1, 1'b0, 32'h3, 1'b1, 1'b0, r);   // full: pop only
        n_checks++;
        if (r !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop ready: got %b expected 0", r);
        end
        step(1'b1, 1'b0, 32'h3, 1'b0, 1'b0, r);
        n_checks++;
        if (r !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop retry ready: got %b expected 1", r);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, r);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, r);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, r);
        n_checks++;
        if (log0.size() != 3 || log0[0] !== 32'h1 || log0[1] !== 32'h2 || log0[2] !== 32'h3) begin
            n_fail++;
            $display("FAIL full_pop order: got %p expected 1,2,3", log0);
        end
        drain();
    endtask

    task automatic test_streaming();
        logic r;
        int   not_ready = 0;
        logic ok0, ok1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[0], WIDTH'(i), 1'b1, 1'b1, r);
            if (r !== 1'b1) not_ready++;
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, r);
        n_checks++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL stream in_ready: got %0d stalls expected 0", not_ready);
        end
        ok0 = (log0.size() == 8);
        ok1 = (log1.size() == 8);
        for (int k = 0; k < 8; k++) begin
            if (ok0 && log0[k] !== WIDTH'(2 * k))     ok0 = 1'b0;
            if (ok1 && log1[k] !== WIDTH'(2 * k + 1)) ok1 = 1'b0;
        end
        n_checks++;
        if (!ok0) begin
            n_fail++;
            $display("FAIL stream ch0: got %p expected 0,2,..,14", log0);
        end
        n_checks++;
        if (!ok1) begin
            n_fail++;
            $display("FAIL stream ch1: got %p expected 1,3,..,15", log1);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic r;
        step(1'b1, 1'b0, 32'hC0, 1'b0, 1'b0, r);
        step(1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, r);
        step(1'b1, 1'b0, 32'hC2, 1'b0, 1'b0, r);
        step(1'b1, 1'b1, 32'hC3, 1'b0, 1'b0, r);
        in_valid = 1'b0;
        #2 rst_aL = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        q0.delete();
        q1.delete();
        #1 rst_aL = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, r);
        // One word buffered: channel 0 still has room.
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, r);
        n_checks++;
        if (r !== 1'b1 || out0_data !== 32'hD0) begin
            n_fail++;
            $display("FAIL reset_mid first push: got ready=%b d0=%h expected 1 d0", r, out0_data);
        end
        drain();
    endtask

    task automatic test_random();
        logic r;
        int   pushed = 0;
        int   popped = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), r);
            popped += log0.size() + log1.size();
            log0.delete();
            log1.delete();
        end
        pushed = popped + q0.size() + q1.size();
        drain();
        n_checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || pushed == 0) begin
            n_fail++;
            $display("FAIL random drain: got v0=%b v1=%b words=%0d expected 0 0 >0",
                     out0_valid, out1_valid, pushed);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill_ch1();
        test_full_pop();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 Parameter WIDTH, default 32, is the payload width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_aL  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  input  1  upstream has a word on in_data.
REQ-005 in_ready  output  1  block accepts the word this cycle.
REQ-006 in_sel  input  1  destination of the word (0 -> channel 0, 1 -> channel 1).
REQ-007 in_data  input  WIDTH  payload.
REQ-008 out0_valid  output  1  channel 0 holds a word.
REQ-009 out0_ready  input  1  channel 0 consumer takes the word this cycle.
REQ-010 out0_data  output  WIDTH  channel 0 head word.
REQ-011 out1_valid, out1_ready, out1_data  output/input/output  1/1/WIDTH  same meaning for channel 1.

Function
REQ-012 The block SHALL route each accepted input word to exactly one of two output channels, selected by in_sel sampled in the accept cycle.
REQ-013 An input transfer SHALL occur only in a cycle where in_valid and in_ready are both 1; an output transfer only where outN_valid and outN_ready are both 1.
REQ-014 Each channel SHALL own a 2-entry FIFO with a 2-bit occupancy count (0..2), a 1-bit write pointer and a 1-bit read pointer.
REQ-015 in_ready SHALL equal "occupancy of channel in_sel is not 2"; combinational from in_sel and registered counts only, never from outN_ready (no pass-through).
REQ-016 in_sel and in_data SHALL be ignored when in_valid is 0; in_ready may toggle with in_sel while in_valid is 0.
REQ-017 outN_valid SHALL equal "occupancy of channel N is not 0"; outN_data SHALL be the entry at channel N read pointer, driven directly from storage.
REQ-018 Latency SHALL be exactly 1 cycle: a word accepted at edge k is visible on outN_data with outN_valid=1 after edge k; no same-cycle bypass.
REQ-019 Per channel, words SHALL leave in acceptance order; no ordering is guaranteed between channels.
REQ-020 Push only: count +1, write pointer toggles. Pop only: count -1, read pointer toggles. Push and pop same cycle: count unchanged, both pointers toggle.
REQ-021 Full (count 2): in_ready=0 for that channel even if outN_ready=1 in the same cycle; the pop still occurs.
REQ-022 Empty (count 0): outN_ready is ignored; no pointer or count change.
REQ-023 Pointer wrap-around (1 -> 0) SHALL be seamless; occupancy is tracked by count, not by pointer comparison.
REQ-024 A push to one channel and a pop from the other in the same cycle SHALL both complete independently.
REQ-025 Full channel SHALL not block acceptance of words selected for the other channel (no head-of-line blocking).

Reset
REQ-026 While rst_aL=0, independent of clk: counts=0, pointers=0, out0_valid=0, out1_valid=0, all storage entries=0 (so outN_data=0).
REQ-027 Reset asserted mid-operation SHALL discard all buffered words immediately; in_ready SHALL read 1 for both in_sel values during and after reset.
REQ-028 First transfer SHALL be possible on the first rising clk edge after rst_aL deasserts.

Structure
REQ-029 No shared package is needed; depth 2 is a local constant and WIDTH the only parameter.
REQ-030 Per-channel storage SHALL be one sub-module fifo2 (ports clk, rst_aL, push, pop, wdata, rdata, full, empty), instantiated twice; the top holds only select steering and ready/valid glue.

Verification
REQ-031 Reset, then in_valid=1, in_sel=0, in_data=0xA5A5A5A5, out0_ready=0 -> next cycle out0_valid=1, out0_data=0xA5A5A5A5, out1_valid=0.
REQ-032 Channel 1 fill: push 0x11, 0x22 with out1_ready=0 -> out1 count 2, in_ready=0 when in_sel=1, in_ready=1 when in_sel=0; push 0x33 to channel 0 accepted.
REQ-033 Full plus pop: channel 0 full (0x1,0x2), in_sel=0, in_valid=1, out0_ready=1 -> 0x1 popped, no push that cycle; next cycle push accepted, then pops yield 0x2, then the new word.
REQ-034 Streaming: alternate in_sel 0/1 with data 0..15, both outN_ready=1 every cycle -> in_ready constantly 1, channel 0 emits 0,2,..,14 and channel 1 emits 1,3,..,15, each 1 cycle after accept.
REQ-035 Reset mid-stream: both channels holding 2 words, pull rst_aL low between edges -> outN_valid=0 immediately, after release first push appears with count 1.
REQ-036 Randomized ready/valid with scoreboard per channel for 10000 cycles -> no loss, duplication or reorder; outN_valid never 1 with count 0.
